// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: MEM-stage data memory sequencer.
// Word/byte loads and stores; byte stores are a single atomic read-modify-write.
// Memory is single-port with a registered read (data one cycle after address).
// Optional feature macro: MEMCTRL_LB_SIGNEXT_EN (byte loads sign-extend when defined).
module mem_byte_ctrl #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 req_we,
  input  logic                 req_byte,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS+1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 byte_q, byte_d;
  logic                 err_q, err_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          rdata_q, rdata_d;

  // Address bits above the memory window wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

  // Lane shift for the latched byte address.
  logic [4:0]  lane_sh;
  logic [7:0]  lane_b;
  logic [31:0] lane_ext;
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign lane_b  = 8'(mem_dout >> lane_sh);
`ifdef MEMCTRL_LB_SIGNEXT_EN
  assign lane_ext = {{24{lane_b[7]}}, lane_b};
`else
  assign lane_ext = {24'b0, lane_b};
`endif

  // State and datapath registers; reset aborts any operation at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and register updates; load result is formed in WAIT so it is
  // already valid while done is high.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    byte_d  = byte_q;
    err_d   = err_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = req_addr[ADDR_BITS+1:0];
          wdata_d = req_wdata;
          we_d    = req_we;
          byte_d  = req_byte;
          err_d   = 1'b0;
          if (!req_byte && (req_addr[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (req_we && !req_byte) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        if (we_q) begin
          data_d  = (mem_dout & ~(32'h0000_00FF << lane_sh)) |
                    ({24'b0, wdata_q[7:0]} << lane_sh);
          state_d = S_WRITE;
        end else begin
          data_d  = mem_dout;
          rdata_d = byte_q ? lane_ext : mem_dout;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done & err_q;
  assign rdata    = rdata_q;
  assign mem_we   = (state_q == S_WRITE);
  assign mem_addr = addr_q[ADDR_BITS+1:2];
  assign mem_din  = byte_q ? data_q : wdata_q;

endmodule
